// File: rtl/minicpu_stack_alu.sv
// minicpu_stack_alu: DEPTH-entry, WIDTH-bit register-stack ALU for the MiniCPU sequencer.
// Define MINICPU_STACK_ALU_MUL_EN to build the multi-cycle shift-add MUL (I=10011).
module minicpu_stack_alu #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             CE,
  input  logic [4:0]       I,
  input  logic             Ld,
  input  logic [WIDTH-1:0] DI,
  input  logic [WIDTH-1:0] Op,
  input  logic             ErrClr,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic             Z,
  output logic             Cy,
  output logic [CW-1:0]    Cnt,
  output logic             Full,
  output logic             Empty,
  output logic             Ovf,
  output logic             Unf,
  output logic             Busy,
  output logic             Done
);

  logic [WIDTH-1:0] stk_q [DEPTH];
  logic [WIDTH-1:0] stk_d [DEPTH];
  logic             cy_q, cy_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             busy;
  logic             do_push, do_pop, wr_tos, do_swap, do_rot;
  logic [WIDTH-1:0] push_val, tos_val;
  logic [CW-1:0]    need;
  logic [WIDTH:0]   alu_sum;
  logic             ovf_err, unf_err;

`ifdef MINICPU_STACK_ALU_MUL_EN
  localparam int SW = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_MUL} state_e;
  state_e             state_q, state_d;
  logic [SW-1:0]      step_q, step_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               mul_start, mul_fin;
  logic               done_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (mul_start) state_d = S_MUL;
      S_MUL:  if (mul_fin)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == S_MUL);
    mul_fin = busy && (step_q == SW'(WIDTH - 1));
  end

  // One partial product per cycle; the final step's sum is written straight to A/B.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    step_d   = step_q;
    if (mul_start) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, stk_q[0]};
      mplier_d = stk_q[1];
      step_d   = '0;
    end else if (busy) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : {2*WIDTH{1'b0}});
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      step_d   = step_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      step_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      step_q   <= step_d;
      done_q   <= mul_fin;
    end
  end

  assign Done = done_q;
`else
  assign busy = 1'b0;
  assign Done = 1'b0;
`endif

  always_comb begin
    do_push  = 1'b0;
    do_pop   = 1'b0;
    wr_tos   = 1'b0;
    do_swap  = 1'b0;
    do_rot   = 1'b0;
    push_val = '0;
    tos_val  = '0;
    need     = '0;
    alu_sum  = '0;
    cy_d     = cy_q;
`ifdef MINICPU_STACK_ALU_MUL_EN
    mul_start = 1'b0;
`endif
    if (CE && !busy) begin
      if (Ld) begin
        do_push  = 1'b1;
        push_val = DI;
      end else begin
        case (I)
          5'b00011, 5'b00100: begin
            do_pop = 1'b1;
            need   = CW'(1);
          end
          5'b00110: begin
            do_push  = 1'b1;
            push_val = Op;
          end
          5'b01000, 5'b01001: begin
            if (I[0]) alu_sum = {1'b0, stk_q[1]} + {1'b0, ~stk_q[0]} + {{WIDTH{1'b0}}, cy_q};
            else      alu_sum = {1'b0, stk_q[1]} + {1'b0, stk_q[0]}  + {{WIDTH{1'b0}}, cy_q};
            do_pop  = 1'b1;
            wr_tos  = 1'b1;
            tos_val = alu_sum[WIDTH-1:0];
            cy_d    = alu_sum[WIDTH];
            need    = CW'(2);
          end
          5'b01010, 5'b01011, 5'b01100: begin
            do_pop = 1'b1;
            wr_tos = 1'b1;
            need   = CW'(2);
            case (I[2:0])
              3'b010:  tos_val = stk_q[1] & stk_q[0];
              3'b011:  tos_val = stk_q[1] | stk_q[0];
              default: tos_val = stk_q[1] ^ stk_q[0];
            endcase
          end
          5'b01101: begin
            wr_tos  = 1'b1;
            tos_val = {cy_q, stk_q[0][WIDTH-1:1]};
            cy_d    = stk_q[0][0];
            need    = CW'(1);
          end
          5'b01110: begin
            wr_tos  = 1'b1;
            tos_val = {stk_q[0][WIDTH-2:0], cy_q};
            cy_d    = stk_q[0][WIDTH-1];
            need    = CW'(1);
          end
          5'b10000: begin
            do_push  = 1'b1;
            push_val = stk_q[0];
            need     = CW'(1);
          end
          5'b10001: begin
            do_swap = 1'b1;
            need    = CW'(2);
          end
          5'b10010: begin
            do_rot = 1'b1;
            need   = CW'(3);
          end
`ifdef MINICPU_STACK_ALU_MUL_EN
          5'b10011: begin
            mul_start = 1'b1;
            need      = CW'(2);
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // Net-pop ALU ops pop first, then overwrite the new TOS with the result.
  always_comb begin
    stk_d   = stk_q;
    cnt_d   = cnt_q;
    ovf_err = 1'b0;
    unf_err = (cnt_q < need);
    if (do_push) begin
      for (int unsigned k = 1; k < DEPTH; k++) stk_d[k] = stk_q[k-1];
      stk_d[0] = push_val;
      if (cnt_q == CW'(DEPTH)) ovf_err = 1'b1;
      else                     cnt_d   = cnt_q + 1'b1;
    end
    if (do_pop) begin
      for (int unsigned k = 0; k < DEPTH - 1; k++) stk_d[k] = stk_q[k+1];
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
    if (wr_tos) stk_d[0] = tos_val;
    if (do_swap) begin
      stk_d[0] = stk_q[1];
      stk_d[1] = stk_q[0];
    end
    if (do_rot) begin
      stk_d[0] = stk_q[2];
      stk_d[1] = stk_q[0];
      stk_d[2] = stk_q[1];
    end
`ifdef MINICPU_STACK_ALU_MUL_EN
    if (mul_fin) begin
      stk_d[0] = acc_d[WIDTH-1:0];
      stk_d[1] = acc_d[2*WIDTH-1:WIDTH];
    end
`endif
    ovf_d = ovf_err | (ovf_q & ~(CE & ErrClr));
    unf_d = unf_err | (unf_q & ~(CE & ErrClr));
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) stk_q[k] <= '0;
      cy_q  <= 1'b0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) stk_q[k] <= stk_d[k];
      cy_q  <= cy_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign A     = stk_q[0];
  assign B     = stk_q[1];
  assign C     = stk_q[2];
  assign Z     = (stk_q[0] == '0);
  assign Cy    = cy_q;
  assign Cnt   = cnt_q;
  assign Full  = (cnt_q == CW'(DEPTH));
  assign Empty = (cnt_q == '0);
  assign Ovf   = ovf_q;
  assign Unf   = unf_q;
  assign Busy  = busy;

endmodule

// File: tb/tb_minicpu_stack_alu.sv
// Randomised self-checking bench for minicpu_stack_alu against a queue-based stack model.
// MUL checks are compiled in when MINICPU_STACK_ALU_MUL_EN is defined.
module tb_minicpu_stack_alu;
  localparam int W  = 6;
  localparam int D  = 8;
  localparam int CW = $clog2(D + 1);
  localparam int unsigned M = 1 << W;

  localparam logic [4:0] OP_NOP = 5'b00000, OP_ST = 5'b00100, OP_LDK = 5'b00110,
                         OP_ADC = 5'b01000, OP_RRC = 5'b01101, OP_DUP = 5'b10000,
                         OP_SWAP = 5'b10001, OP_ROT = 5'b10010, OP_MUL = 5'b10011;

  logic          Clk = 1'b0, Rst = 1'b0, CE = 1'b0, Ld = 1'b0, ErrClr = 1'b0;
  logic [4:0]    I = '0;
  logic [W-1:0]  DI = '0, Op = '0;
  logic [W-1:0]  A, B, C;
  logic          Z, Cy, Full, Empty, Ovf, Unf, Busy, Done;
  logic [CW-1:0] Cnt;

  minicpu_stack_alu #(.WIDTH(W), .DEPTH(D)) dut (
    .Clk(Clk), .Rst(Rst), .CE(CE), .I(I), .Ld(Ld), .DI(DI), .Op(Op), .ErrClr(ErrClr),
    .A(A), .B(B), .C(C), .Z(Z), .Cy(Cy), .Cnt(Cnt), .Full(Full), .Empty(Empty),
    .Ovf(Ovf), .Unf(Unf), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0, n_fail = 0;

  // Reference model: the stack is a queue that always holds D words, front = TOS.
  int unsigned mq[$];
  int unsigned mcnt, mcy, mprod;
  bit          movf, munf, mbusy, mdone;
  int          mleft;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit m_push(input int unsigned v);
    mq.push_front(v % M);
    void'(mq.pop_back());
    if (mcnt == D) return 1'b1;
    mcnt++;
    return 1'b0;
  endfunction

  function automatic void m_pop();
    void'(mq.pop_front());
    mq.push_back(mq[$]);
    if (mcnt > 0) mcnt--;
  endfunction

  task automatic model_reset();
    mq.delete();
    repeat (D) mq.push_back(0);
    mcnt = 0; mcy = 0; movf = 0; munf = 0; mbusy = 0; mdone = 0; mleft = 0; mprod = 0;
  endtask

  task automatic model_edge();
    bit eo = 0, eu = 0;
    int unsigned a, b, c, s, need = 0, cnt0;
    cnt0  = mcnt;
    mdone = 0;
    if (mbusy) begin
      mleft--;
      if (mleft == 0) begin
        mq[0] = mprod % M; mq[1] = mprod / M; mbusy = 0; mdone = 1;
      end
    end else if (CE) begin
      a = mq[0]; b = mq[1]; c = mq[2];
      if (Ld) eo = m_push(DI);
      else case (I)
        5'b00011, 5'b00100: begin need = 1; m_pop(); end
        5'b00110: eo = m_push(Op);
        5'b01000: begin need = 2; s = b + a + mcy; m_pop(); mq[0] = s % M; mcy = s / M; end
        5'b01001: begin need = 2; s = b + (M - 1 - a) + mcy; m_pop(); mq[0] = s % M; mcy = s / M; end
        5'b01010: begin need = 2; m_pop(); mq[0] = b & a; end
        5'b01011: begin need = 2; m_pop(); mq[0] = b | a; end
        5'b01100: begin need = 2; m_pop(); mq[0] = b ^ a; end
        5'b01101: begin need = 1; mq[0] = (mcy << (W - 1)) | (a >> 1); mcy = a & 1; end
        5'b01110: begin need = 1; mq[0] = ((a << 1) | mcy) % M; mcy = a >> (W - 1); end
        5'b10000: begin need = 1; eo = m_push(a); end
        5'b10001: begin need = 2; mq[0] = b; mq[1] = a; end
        5'b10010: begin need = 3; mq[0] = c; mq[1] = a; mq[2] = b; end
`ifdef MINICPU_STACK_ALU_MUL_EN
        5'b10011: begin need = 2; mbusy = 1; mleft = W; mprod = a * b; end
`endif
        default: ;
      endcase
      eu = (cnt0 < need);
    end
    if (CE && ErrClr) begin movf = 0; munf = 0; end
    movf = movf | eo;
    munf = munf | eu;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".A"}, A, mq[0]);
    chk({ctx, ".B"}, B, mq[1]);
    chk({ctx, ".C"}, C, mq[2]);
    chk({ctx, ".Z"}, Z, mq[0] == 0);
    chk({ctx, ".Cy"}, Cy, mcy);
    chk({ctx, ".Cnt"}, Cnt, mcnt);
    chk({ctx, ".Full"}, Full, mcnt == D);
    chk({ctx, ".Empty"}, Empty, mcnt == 0);
    chk({ctx, ".Ovf"}, Ovf, movf);
    chk({ctx, ".Unf"}, Unf, munf);
    chk({ctx, ".Busy"}, Busy, mbusy);
    chk({ctx, ".Done"}, Done, mdone);
  endtask

  task automatic cyc(input bit ce, input logic [4:0] i, input bit ld, input logic [W-1:0] di,
                     input logic [W-1:0] op, input bit clr, input string ctx);
    CE = ce; I = i; Ld = ld; DI = di; Op = op; ErrClr = clr;
    @(posedge Clk);
    model_edge();
    #1;
    check_all(ctx);
  endtask

  task automatic do_op(input logic [4:0] i, input string ctx);
    cyc(1'b1, i, 1'b0, '0, '0, 1'b0, ctx);
  endtask

  task automatic ldk(input logic [W-1:0] v);
    cyc(1'b1, OP_LDK, 1'b0, '0, v, 1'b0, "ldk");
  endtask

  task automatic apply_reset();
    CE = 0; Ld = 0; ErrClr = 0; I = '0;
    Rst = 1'b1;
    #2;
    model_reset();
    check_all("rst");
    @(posedge Clk);
    #1;
    Rst = 1'b0;
  endtask

  initial begin
    logic [4:0] pick [10] = '{5'b00011, 5'b00100, 5'b00110, 5'b01000, 5'b01001,
                              5'b01101, 5'b01110, 5'b10000, 5'b10001, 5'b10010};
    int nb;
    logic [4:0] ri;

    apply_reset();
    chk("rst_A", A, 0); chk("rst_Cnt", Cnt, 0); chk("rst_Empty", Empty, 1); chk("rst_Busy", Busy, 0);

    ldk(5); ldk(3); do_op(OP_ADC, "adc1");
    chk("adc1_A", A, 8); chk("adc1_Cnt", Cnt, 1); chk("adc1_Cy", Cy, 0); chk("adc1_Unf", Unf, 0);

    apply_reset();
    ldk(63); ldk(1); do_op(OP_ADC, "adc_wrap");
    chk("wrap_A", A, 0); chk("wrap_Cy", Cy, 1); chk("wrap_Z", Z, 1);
    ldk(0); do_op(OP_RRC, "rrc");
    chk("rrc_A", A, 32); chk("rrc_Cy", Cy, 0);

    apply_reset();
    for (int v = 1; v <= 9; v++) cyc(1'b1, OP_NOP, 1'b1, W'(v), '0, 1'b0, "ldpush");
    chk("full_Full", Full, 1); chk("full_Ovf", Ovf, 1); chk("full_Cnt", Cnt, 8); chk("full_A", A, 9);
    cyc(1'b1, OP_NOP, 1'b0, '0, '0, 1'b1, "errclr");
    chk("clr_Ovf", Ovf, 0);
    repeat (7) do_op(OP_ST, "pop");
    chk("bottom_A", A, 2);

    apply_reset();
    do_op(OP_ADC, "adc_empty");
    chk("unf_Unf", Unf, 1); chk("unf_Cnt", Cnt, 0);
    cyc(1'b1, OP_ST, 1'b0, '0, '0, 1'b1, "clr_pop0");
    chk("clrpop_Unf", Unf, 1); chk("clrpop_Cnt", Cnt, 0);

    apply_reset();
    ldk(1); ldk(2); ldk(3);
    do_op(OP_ROT, "rot");
    chk("rot_A", A, 1); chk("rot_B", B, 3); chk("rot_C", C, 2);
    do_op(OP_SWAP, "swap");
    chk("swap_A", A, 3); chk("swap_B", B, 1);
    do_op(OP_DUP, "dup");
    chk("dup_A", A, 3); chk("dup_B", B, 3); chk("dup_Cnt", Cnt, 4);
    cyc(1'b0, OP_ADC, 1'b1, 7, 7, 1'b0, "ce_low");
    chk("celow_A", A, 3); chk("celow_Cnt", Cnt, 4);

`ifdef MINICPU_STACK_ALU_MUL_EN
    apply_reset();
    ldk(9); ldk(7); do_op(OP_MUL, "mul_start");
    chk("mul_Busy0", Busy, 1);
    nb = 1;
    while (Busy && nb < 20) begin
      cyc(1'b0, OP_NOP, 1'b0, '0, '0, 1'b0, "mul_run");
      if (Busy) nb++;
    end
    chk("mul_busy_len", nb, W);
    chk("mul_A", A, 63); chk("mul_B", B, 0); chk("mul_Done", Done, 1); chk("mul_Cnt", Cnt, 2);
    cyc(1'b0, OP_NOP, 1'b0, '0, '0, 1'b0, "mul_after");
    chk("mul_Done_off", Done, 0);

    apply_reset();
    ldk(9); ldk(7); do_op(OP_MUL, "mul2_start");
    repeat (2) cyc(1'b0, OP_NOP, 1'b0, '0, '0, 1'b0, "mul2_run");
    apply_reset();
    chk("abort_A", A, 0); chk("abort_B", B, 0); chk("abort_Busy", Busy, 0); chk("abort_Cnt", Cnt, 0);
`else
    apply_reset();
    ldk(9); ldk(7); do_op(OP_MUL, "mul_nop");
    chk("mulnop_A", A, 7); chk("mulnop_B", B, 9); chk("mulnop_Busy", Busy, 0);
`endif

    apply_reset();
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 1) == 0) ri = pick[$urandom_range(0, 9)];
      else                           ri = 5'($urandom_range(0, 31));
      cyc($urandom_range(0, 9) != 0, ri, $urandom_range(0, 7) == 0,
          W'($urandom), W'($urandom), 1'b0, "rnd");
      if ($urandom_range(0, 15) == 0) cyc(1'b1, OP_NOP, 1'b0, '0, '0, 1'b1, "rnd_clr");
      if ($urandom_range(0, 399) == 0) apply_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
